// File: rtl/serial_deserializer8.sv
// serial_deserializer8: serial-to-parallel receiver with a one-word output
// holding register (valid/ready) and a sticky overrun flag for dropped words.
module serial_deserializer8 #(
  parameter int WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       serial_in,
  input  logic                       serial_valid,
  input  logic                       dir,
  input  logic                       frame_start,
  input  logic                       out_ready,
  input  logic                       clear_err,
  output logic [WIDTH-1:0]           OUT,
  output logic                       out_valid,
  output logic                       overrun,
  output logic                       busy,
  output logic [$clog2(WIDTH+1)-1:0] bit_count
);

  localparam int CW = $clog2(WIDTH+1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RECV = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [WIDTH-1:0] shift_q, shift_d, base, word;
  logic             dir_q, dir_d, dsel;
  logic             accept, fs, first, complete;

  logic [WIDTH-1:0] out_q, out_d;
  logic             vld_q, vld_d;
  logic             ovr_q, ovr_d;
  logic             drop;

  // Receive side: bit capture, direction latch and word completion.
  always_comb begin
    accept   = enable & serial_valid;
    fs       = enable & frame_start;
    // A word starts either from IDLE or on a resync; the partial word is discarded.
    first    = fs | (state_q == IDLE);
    dsel     = first ? dir : dir_q;
    base     = first ? '0 : shift_q;
    word     = dsel ? {base[WIDTH-2:0], serial_in} : {serial_in, base[WIDTH-1:1]};
    cnt_inc  = first ? CW'(1) : cnt_q + CW'(1);
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    dir_d    = dir_q;
    complete = 1'b0;
    if (accept) begin
      dir_d   = dsel;
      shift_d = word;
      if (cnt_inc == CW'(WIDTH)) begin
        complete = 1'b1;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end else if (fs) begin
      cnt_d = '0;
    end
    state_d = (cnt_d == '0) ? IDLE : RECV;
  end

  // Output side: holding register, handshake and sticky overrun.
  always_comb begin
    drop  = complete & vld_q & ~out_ready;
    out_d = out_q;
    vld_d = vld_q;
    if (complete && !drop) begin
      out_d = word;
      vld_d = 1'b1;
    end else if (!complete && out_ready) begin
      vld_d = 1'b0;
    end
    // A drop on the same edge as clear_err keeps the flag set.
    ovr_d = drop ? 1'b1 : (clear_err ? 1'b0 : ovr_q);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      dir_q   <= 1'b0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      dir_q   <= dir_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
    end
  end

  assign OUT       = out_q;
  assign out_valid = vld_q;
  assign overrun   = ovr_q;
  assign bit_count = cnt_q;
  assign busy      = (cnt_q != '0);

endmodule

// File: tb/tb_serial_deserializer8.sv
// Self-checking bench for serial_deserializer8: directed words, expected
// words queued by the driver, popped by a monitor on each output handshake.
module tb_serial_deserializer8;

  logic       clock = 1'b0;
  logic       reset, enable, serial_in, serial_valid, dir, frame_start;
  logic       out_ready, clear_err;
  logic [7:0] OUT;
  logic       out_valid, overrun, busy;
  logic [3:0] bit_count;

  int checks = 0;
  int errors = 0;
  logic [7:0] expq[$];

  serial_deserializer8 #(.WIDTH(8)) dut (
    .clock(clock), .reset(reset), .enable(enable), .serial_in(serial_in),
    .serial_valid(serial_valid), .dir(dir), .frame_start(frame_start),
    .out_ready(out_ready), .clear_err(clear_err), .OUT(OUT),
    .out_valid(out_valid), .overrun(overrun), .busy(busy), .bit_count(bit_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs at a falling edge, return at the next falling edge.
  task automatic cyc(input logic en, input logic sv, input logic b, input logic d,
                     input logic fs, input logic rdy, input logic clr);
    enable = en; serial_valid = sv; serial_in = b; dir = d;
    frame_start = fs; out_ready = rdy; clear_err = clr;
    @(negedge clock);
  endtask

  task automatic send_word(input logic [7:0] w, input logic d, input logic rdy_last,
                           input logic fs_first);
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 1'b1, d ? w[7-i] : w[i], d, fs_first && (i == 0),
          rdy_last && (i == 7), 1'b0);
  endtask

  task automatic consume();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("valid_after_consume", out_valid, 1'b0);
  endtask

  // Monitor: a word is consumed on any edge where out_valid && out_ready.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clock);
      #2;
      if (reset && out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got %0h expected none", OUT);
        end else begin
          e = expq.pop_front();
          chk("sb_word", OUT, e);
        end
      end
    end
  end

  initial begin
    logic [7:0] w;
    reset = 1'b0; enable = 1'b0; serial_in = 1'b0; serial_valid = 1'b0;
    dir = 1'b0; frame_start = 1'b0; out_ready = 1'b0; clear_err = 1'b0;
    #1;
    chk("rst_out", OUT, 8'h00);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", bit_count, 4'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    // LSB-first 0x5B with per-edge busy/bit_count checks
    w = 8'h5B;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1, w[i], 1'b0, 1'b0, 1'b0, 1'b0);
      if (i < 7) begin
        chk("lsb_busy", busy, 1'b1);
        chk("lsb_count", bit_count, i + 1);
      end
    end
    chk("lsb_out", OUT, 8'h5B);
    chk("lsb_valid", out_valid, 1'b1);
    chk("lsb_count_end", bit_count, 4'd0);
    chk("lsb_busy_end", busy, 1'b0);
    expq.push_back(8'h5B);
    consume();

    // MSB-first 0x5B, dir toggled low after bit 3 (ignored mid-word)
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 1'b1, w[7-i], (i < 3) ? 1'b1 : 1'b0, 1'b0, 1'b0, 1'b0);
    chk("msb_out", OUT, 8'h5B);
    chk("msb_valid", out_valid, 1'b1);
    expq.push_back(8'h5B);
    consume();

    // Back-to-back with stall: second word dropped, overrun set
    send_word(8'h5B, 1'b0, 1'b0, 1'b0);
    expq.push_back(8'h5B);
    send_word(8'hA4, 1'b0, 1'b0, 1'b0);
    chk("stall_out", OUT, 8'h5B);
    chk("stall_overrun", overrun, 1'b1);
    chk("stall_valid", out_valid, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("clear_overrun", overrun, 1'b0);
    consume();

    // Simultaneous consume and complete
    send_word(8'h5B, 1'b0, 1'b0, 1'b0);
    expq.push_back(8'h5B);
    send_word(8'h3C, 1'b0, 1'b1, 1'b0);
    expq.push_back(8'h3C);
    chk("simul_out", OUT, 8'h3C);
    chk("simul_valid", out_valid, 1'b1);
    chk("simul_overrun", overrun, 1'b0);
    consume();

    // frame_start resync after 3 garbage bits
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("garbage_count", bit_count, 4'd3);
    w = 8'h81;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1, w[i], 1'b0, i == 0, 1'b0, 1'b0);
      if (i == 0) chk("resync_count", bit_count, 4'd1);
    end
    chk("resync_out", OUT, 8'h81);
    chk("resync_valid", out_valid, 1'b1);
    expq.push_back(8'h81);
    consume();

    // Asynchronous reset mid-word, between clock edges
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_count", bit_count, 4'd5);
    serial_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("arst_out", OUT, 8'h00);
    chk("arst_count", bit_count, 4'd0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_valid", out_valid, 1'b0);
    #1 reset = 1'b1;
    @(negedge clock);
    send_word(8'h96, 1'b0, 1'b0, 1'b0);
    chk("post_rst_out", OUT, 8'h96);
    chk("post_rst_valid", out_valid, 1'b1);
    expq.push_back(8'h96);
    consume();

    // enable low for 3 cycles mid-word (frame_start gated too)
    w = 8'hC3;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        for (int k = 0; k < 3; k++) begin
          cyc(1'b0, 1'b1, ~w[i], 1'b0, k == 1, 1'b0, 1'b0);
          chk("frozen_count", bit_count, 4'd3);
        end
      end
      cyc(1'b1, 1'b1, w[i], 1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("en_out", OUT, 8'hC3);
    chk("en_valid", out_valid, 1'b1);
    expq.push_back(8'hC3);
    consume();

    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sb_drained", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
